// File: rtl/cdru_pkg.sv
// Shared definitions for the banked conflict-detection read unit.
// - clog2: ceiling log2, used to size select and age fields.
// - bank_field / word_field: split a request address into bank and word parts.
// - pipe_entry_t: one slot of the per-bank return pipeline {vld, sel}.
// Optional feature macro used by the files that import this package: CDRU_STARVE_GUARD_EN.
package cdru_pkg;

  // Widest requester index the return pipeline can carry.
  localparam int unsigned MaxSelW = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned n;
    v = (value > 0) ? value - 1 : 0;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  function automatic int unsigned bank_field(input logic [31:0] addr,
                                             input int unsigned wordbits,
                                             input int unsigned bankbits);
    logic [31:0] mask;
    mask = (32'd1 << bankbits) - 32'd1;
    return (addr >> wordbits) & mask;
  endfunction

  function automatic int unsigned word_field(input logic [31:0] addr,
                                             input int unsigned wordbits);
    logic [31:0] mask;
    mask = (32'd1 << wordbits) - 32'd1;
    return addr & mask;
  endfunction

  typedef struct packed {
    logic               vld;
    logic [MaxSelW-1:0] sel;
  } pipe_entry_t;

endpackage

// File: rtl/cdru_bank_pick.sv
// Per-bank winner selection, purely combinational.
// - cand_i   : requesters that want this bank this cycle.
// - urgent_i : requesters whose age has saturated (only with CDRU_STARVE_GUARD_EN).
// - hit_o    : bank has at least one candidate.
// - win_o    : index of the winning requester (lowest index, urgent ones first).
module cdru_bank_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned SELW = 2
) (
  input  logic [NREQ-1:0] cand_i,
`ifdef CDRU_STARVE_GUARD_EN
  input  logic [NREQ-1:0] urgent_i,
`endif
  output logic            hit_o,
  output logic [SELW-1:0] win_o
);

  logic [NREQ-1:0] pool;

  always_comb begin
    pool = cand_i;
`ifdef CDRU_STARVE_GUARD_EN
    // Any urgent candidate shadows every non-urgent one.
    if (|(cand_i & urgent_i)) begin
      pool = cand_i & urgent_i;
    end
`endif
    hit_o = |cand_i;
    win_o = '0;
    // Scan downwards so the lowest set index is the last writer.
    for (int r = int'(NREQ) - 1; r >= 0; r--) begin
      if (pool[r]) begin
        win_o = SELW'(r);
      end
    end
  end

endmodule

// File: rtl/cdru_banked_arb.sv
// Conflict-detection read unit for a banked scratchpad.
// Grants every non-conflicting requester each cycle (one per bank), registers the per-bank
// read command and delays the winner index by the bank read latency so read data can be
// steered back to its owner.
// Optional feature: CDRU_STARVE_GUARD_EN adds per-requester age counters that promote
// long-denied requesters to urgent.
// Ports:
// - clk_i        clock
// - rst_i        synchronous active-high reset
// - req_en_i     request valid per requester
// - req_addr_i   request address, requester r at [r*A +: A]
// - req_grnt_o   combinational grant
// - bank_en_o    registered read enable per bank
// - bank_word_o  registered word address per bank
// - bank_sel_o   registered winner index per bank
// - rd_vld_o     bank_en delayed by RDLAT
// - rd_sel_o     bank_sel delayed by RDLAT
module cdru_banked_arb
  import cdru_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned BANKBITS = 5,
  parameter int unsigned WORDBITS = 9,
  parameter int unsigned RDLAT    = 2,
  parameter int unsigned AGEMAX   = 7,
  localparam int unsigned NBANK   = 2 ** BANKBITS,
  localparam int unsigned A       = BANKBITS + WORDBITS,
  localparam int unsigned SELW    = (NREQ > 1) ? clog2(NREQ) : 1,
  localparam int unsigned AGEW    = (AGEMAX > 1) ? clog2(AGEMAX + 1) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NREQ-1:0]           req_en_i,
  input  logic [NREQ*A-1:0]         req_addr_i,
  output logic [NREQ-1:0]           req_grnt_o,
  output logic [NBANK-1:0]          bank_en_o,
  output logic [NBANK*WORDBITS-1:0] bank_word_o,
  output logic [NBANK*SELW-1:0]     bank_sel_o,
  output logic [NBANK-1:0]          rd_vld_o,
  output logic [NBANK*SELW-1:0]     rd_sel_o
);

  logic [NREQ-1:0]     cand [NBANK];
  logic [NBANK-1:0]    hit;
  logic [SELW-1:0]     win [NBANK];
  logic [WORDBITS-1:0] win_word [NBANK];

  logic [NBANK-1:0]    bank_en_q;
  logic [WORDBITS-1:0] bank_word_q [NBANK];
  logic [SELW-1:0]     bank_sel_q [NBANK];
  pipe_entry_t         pipe_q [NBANK][RDLAT];

  // Candidate matrix; reset masks every request so no grant escapes during rst_i.
  always_comb begin
    for (int unsigned b = 0; b < NBANK; b++) begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        cand[b][r] = ~rst_i & req_en_i[r] &
                     (bank_field(32'(req_addr_i[r*A +: A]), WORDBITS, BANKBITS) == b);
      end
    end
  end

`ifdef CDRU_STARVE_GUARD_EN
  logic [AGEW-1:0] age_q [NREQ];
  logic [AGEW-1:0] age_d [NREQ];
  logic [NREQ-1:0] urgent;

  always_comb begin
    for (int unsigned r = 0; r < NREQ; r++) begin
      urgent[r] = (age_q[r] == AGEW'(AGEMAX));
      if (req_en_i[r] && !req_grnt_o[r]) begin
        age_d[r] = urgent[r] ? age_q[r] : age_q[r] + AGEW'(1);
      end else begin
        age_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (rst_i) begin
        age_q[r] <= '0;
      end else begin
        age_q[r] <= age_d[r];
      end
    end
  end
`endif

  for (genvar gb = 0; gb < NBANK; gb++) begin : g_bank
    cdru_bank_pick #(
      .NREQ (NREQ),
      .SELW (SELW)
    ) u_pick (
      .cand_i   (cand[gb]),
`ifdef CDRU_STARVE_GUARD_EN
      .urgent_i (urgent),
`endif
      .hit_o    (hit[gb]),
      .win_o    (win[gb])
    );
  end

  // Grant is the OR over banks of "this requester won that bank".
  always_comb begin
    req_grnt_o = '0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      win_word[b] = '0;
      for (int unsigned r = 0; r < NREQ; r++) begin
        if (hit[b] && (win[b] == SELW'(r))) begin
          req_grnt_o[r] = 1'b1;
          win_word[b]   = WORDBITS'(word_field(32'(req_addr_i[r*A +: A]), WORDBITS));
        end
      end
    end
  end

  // Command stage: word/sel hold when the bank is idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_en_q <= '0;
      for (int unsigned b = 0; b < NBANK; b++) begin
        bank_word_q[b] <= '0;
        bank_sel_q[b]  <= '0;
      end
    end else begin
      bank_en_q <= hit;
      for (int unsigned b = 0; b < NBANK; b++) begin
        if (hit[b]) begin
          bank_word_q[b] <= win_word[b];
          bank_sel_q[b]  <= win[b];
        end
      end
    end
  end

  // Return pipeline: flushed on reset so in-flight reads never surface.
  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < RDLAT; i++) begin
          pipe_q[b][i] <= '0;
        end
      end else begin
        pipe_q[b][0] <= '{vld: bank_en_q[b], sel: MaxSelW'(bank_sel_q[b])};
        for (int unsigned i = 1; i < RDLAT; i++) begin
          pipe_q[b][i] <= pipe_q[b][i-1];
        end
      end
    end
  end

  always_comb begin
    bank_en_o = bank_en_q;
    for (int unsigned b = 0; b < NBANK; b++) begin
      bank_word_o[b*WORDBITS +: WORDBITS] = bank_word_q[b];
      bank_sel_o[b*SELW +: SELW]          = bank_sel_q[b];
      rd_vld_o[b]                         = pipe_q[b][RDLAT-1].vld;
      rd_sel_o[b*SELW +: SELW]            = pipe_q[b][RDLAT-1].sel[SELW-1:0];
    end
  end

  // Upper select bits of the last stage are always zero and never leave the block.
  logic unused_bits;
  always_comb begin
    unused_bits = 1'b0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      unused_bits = unused_bits ^ (^(pipe_q[b][RDLAT-1].sel >> SELW));
    end
`ifndef CDRU_STARVE_GUARD_EN
    unused_bits = unused_bits ^ (^AGEMAX) ^ (^AGEW);
`endif
  end

endmodule

// File: tb/tb_cdru_banked_arb.sv
module tb_cdru_banked_arb;

  localparam int unsigned NREQ = 3, BANKBITS = 2, WORDBITS = 4, RDLAT = 2, AGEMAX = 3;
  localparam int unsigned NBANK = 4, A = 6, SELW = 2;
`ifdef CDRU_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NREQ-1:0]           req_en = '0;
  logic [NREQ*A-1:0]         req_addr = '0;
  logic [NREQ-1:0]           req_grnt;
  logic [NBANK-1:0]          bank_en;
  logic [NBANK*WORDBITS-1:0] bank_word;
  logic [NBANK*SELW-1:0]     bank_sel;
  logic [NBANK-1:0]          rd_vld;
  logic [NBANK*SELW-1:0]     rd_sel;

  int n_vec = 0;
  int n_err = 0;

  cdru_banked_arb #(
    .NREQ     (NREQ),
    .BANKBITS (BANKBITS),
    .WORDBITS (WORDBITS),
    .RDLAT    (RDLAT),
    .AGEMAX   (AGEMAX)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_en_i    (req_en),
    .req_addr_i  (req_addr),
    .req_grnt_o  (req_grnt),
    .bank_en_o   (bank_en),
    .bank_word_o (bank_word),
    .bank_sel_o  (bank_sel),
    .rd_vld_o    (rd_vld),
    .rd_sel_o    (rd_sel)
  );

  always #5 clk = ~clk;

  // Reference model: arbitration from the priority rules, plus a per-clock history log.
  int                        age [NREQ];
  logic [NBANK-1:0]          m_en = '0;
  logic [NBANK*WORDBITS-1:0] m_word = '0;
  logic [NBANK*SELW-1:0]     m_sel = '0;
  logic [NBANK-1:0]          m_rd_vld = '0;
  logic [NBANK*SELW-1:0]     m_rd_sel = '0;
  logic [NBANK-1:0]          h_en [$];
  logic [NBANK*SELW-1:0]     h_sel [$];
  int                        clk_n = 0;
  int                        last_rst = 0;

  function automatic int addr_of(int r);
    return int'(req_addr[r*A +: A]);
  endfunction

  function automatic int bank_of(int r);
    return (addr_of(r) >> WORDBITS) % NBANK;
  endfunction

  function automatic logic [NREQ-1:0] model_grant();
    logic [NREQ-1:0] g;
    bit taken [NBANK];
    g = '0;
    for (int b = 0; b < NBANK; b++) taken[b] = 0;
    if (rst) return '0;
    // Pass 0 serves urgent requesters, pass 1 the rest, lowest index first in each.
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < NREQ; r++) begin
        bit urg;
        urg = GUARD && (age[r] == AGEMAX);
        if (req_en[r] && (urg == (p == 0)) && !taken[bank_of(r)]) begin
          g[r] = 1'b1;
          taken[bank_of(r)] = 1;
        end
      end
    end
    return g;
  endfunction

  task automatic model_clock();
    logic [NREQ-1:0] g;
    int k;
    clk_n++;
    if (rst) begin
      m_en = '0; m_word = '0; m_sel = '0;
      for (int r = 0; r < NREQ; r++) age[r] = 0;
      last_rst = clk_n;
    end else begin
      g = model_grant();
      m_en = '0;
      for (int r = 0; r < NREQ; r++) begin
        if (g[r]) begin
          m_en[bank_of(r)] = 1'b1;
          m_word[bank_of(r)*WORDBITS +: WORDBITS] = WORDBITS'(addr_of(r) % 16);
          m_sel[bank_of(r)*SELW +: SELW] = SELW'(r);
        end
      end
      for (int r = 0; r < NREQ; r++) begin
        if (req_en[r] && !g[r]) age[r] = (age[r] + 1 > AGEMAX) ? AGEMAX : age[r] + 1;
        else age[r] = 0;
      end
    end
    h_en.push_back(m_en);
    h_sel.push_back(m_sel);
    k = clk_n - RDLAT;
    if (k >= 1 && k >= last_rst) begin
      m_rd_vld = h_en[k-1];
      m_rd_sel = h_sel[k-1];
    end else begin
      m_rd_vld = '0;
      m_rd_sel = '0;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_req(int r, bit en, int addr);
    req_en[r] = en;
    req_addr[r*A +: A] = A'(addr);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1, 'h01); set_req(1, 1, 'h12); set_req(2, 1, 'h23);
    #1;
    n_vec++; if (req_grnt !== 3'b000) begin n_err++; $display("FAIL rst_grnt got=%b want=000", req_grnt); end
    clk_step(); clk_step();
    n_vec++; if (bank_en !== '0) begin n_err++; $display("FAIL rst_bank_en got=%b want=0", bank_en); end
    n_vec++; if (bank_word !== '0) begin n_err++; $display("FAIL rst_bank_word got=%h want=0", bank_word); end
    n_vec++; if (bank_sel !== '0) begin n_err++; $display("FAIL rst_bank_sel got=%h want=0", bank_sel); end
    n_vec++; if (rd_vld !== '0) begin n_err++; $display("FAIL rst_rd_vld got=%b want=0", rd_vld); end
    n_vec++; if (rd_sel !== '0) begin n_err++; $display("FAIL rst_rd_sel got=%h want=0", rd_sel); end
    @(negedge clk);
    rst = 1'b0;
    req_en = '0;
    clk_step(); clk_step();
  endtask

  task automatic test_partial_conflict();
    @(negedge clk);
    set_req(0, 1, 'h13); set_req(1, 1, 'h1A); set_req(2, 1, 'h25);
    #1;
    n_vec++; if (req_grnt !== 3'b101) begin n_err++; $display("FAIL pc_grnt got=%b want=101", req_grnt); end
    clk_step();
    n_vec++; if (bank_en !== 4'b0110) begin n_err++; $display("FAIL pc_bank_en got=%b want=0110", bank_en); end
    n_vec++; if (bank_word[7:4] !== 4'h3) begin n_err++; $display("FAIL pc_word1 got=%h want=3", bank_word[7:4]); end
    n_vec++; if (bank_sel[3:2] !== 2'd0) begin n_err++; $display("FAIL pc_sel1 got=%0d want=0", bank_sel[3:2]); end
    n_vec++; if (bank_word[11:8] !== 4'h5) begin n_err++; $display("FAIL pc_word2 got=%h want=5", bank_word[11:8]); end
    n_vec++; if (bank_sel[5:4] !== 2'd2) begin n_err++; $display("FAIL pc_sel2 got=%0d want=2", bank_sel[5:4]); end
    // Loser keeps asking and now gets the bank alone.
    @(negedge clk);
    set_req(0, 0, 0); set_req(2, 0, 0);
    #1;
    n_vec++; if (req_grnt !== 3'b010) begin n_err++; $display("FAIL pc_grnt2 got=%b want=010", req_grnt); end
    clk_step();
    n_vec++; if (bank_en !== 4'b0010) begin n_err++; $display("FAIL pc_bank_en2 got=%b want=0010", bank_en); end
    n_vec++; if (bank_word[7:4] !== 4'hA) begin n_err++; $display("FAIL pc_word1b got=%h want=a", bank_word[7:4]); end
    n_vec++; if (bank_word[11:8] !== 4'h5) begin n_err++; $display("FAIL pc_word2_hold got=%h want=5", bank_word[11:8]); end
    @(negedge clk);
    req_en = '0;
    clk_step();
    n_vec++; if (rd_vld !== 4'b0110) begin n_err++; $display("FAIL pc_rd_vld got=%b want=0110", rd_vld); end
    n_vec++; if (rd_sel[5:2] !== 4'b1000) begin n_err++; $display("FAIL pc_rd_sel got=%b want=1000", rd_sel[5:2]); end
    clk_step();
    n_vec++; if (rd_vld !== 4'b0010) begin n_err++; $display("FAIL pc_rd_vld2 got=%b want=0010", rd_vld); end
    n_vec++; if (rd_sel[3:2] !== 2'd1) begin n_err++; $display("FAIL pc_rd_sel2 got=%0d want=1", rd_sel[3:2]); end
    clk_step(); clk_step();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        set_req(0, 1, 'h01); set_req(1, 1, 'h12); set_req(2, 1, 'h33);
        #1;
        n_vec++; if (req_grnt !== 3'b111) begin n_err++; $display("FAIL b2b_grnt[%0d] got=%b want=111", k, req_grnt); end
      end else begin
        req_en = '0;
      end
      clk_step();
      if (k <= 4) begin
        n_vec++; if (bank_en !== 4'b1011) begin n_err++; $display("FAIL b2b_bank_en[%0d] got=%b want=1011", k, bank_en); end
      end
      n_vec++;
      if (rd_vld !== ((k >= 3 && k <= 6) ? 4'b1011 : 4'b0000)) begin
        n_err++; $display("FAIL b2b_rd_vld[%0d] got=%b", k, rd_vld);
      end
      if (rd_vld[0] === 1'b1) pulses++;
    end
    n_vec++; if (pulses != 4) begin n_err++; $display("FAIL b2b_pulses got=%0d want=4", pulses); end
  endtask

  task automatic test_starve();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      set_req(0, 1, 'h30); set_req(1, 1, 'h3F); set_req(2, 0, 0);
      #1;
      if (GUARD) begin
        // req1 ages 1,2,3 over three denials, then wins on the fourth cycle.
        n_vec++;
        if (req_grnt !== ((c % 4 == 0) ? 3'b010 : 3'b001)) begin
          n_err++; $display("FAIL starve_guard_grnt[%0d] got=%b", c, req_grnt);
        end
      end else begin
        n_vec++; if (req_grnt !== 3'b001) begin n_err++; $display("FAIL starve_grnt[%0d] got=%b want=001", c, req_grnt); end
      end
      clk_step();
    end
    @(negedge clk);
    req_en = '0;
    clk_step(); clk_step(); clk_step();
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    set_req(0, 1, 'h05);
    #1;
    n_vec++; if (req_grnt !== 3'b001) begin n_err++; $display("FAIL rm_grnt got=%b want=001", req_grnt); end
    clk_step();
    n_vec++; if (bank_en !== 4'b0001) begin n_err++; $display("FAIL rm_bank_en got=%b want=0001", bank_en); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b1;
      set_req(0, 1, 'h06);
      #1;
      n_vec++; if (req_grnt !== 3'b000) begin n_err++; $display("FAIL rm_grnt_rst[%0d] got=%b want=000", c, req_grnt); end
      clk_step();
      n_vec++; if (bank_en !== 4'b0000) begin n_err++; $display("FAIL rm_bank_en_rst[%0d] got=%b want=0000", c, bank_en); end
      n_vec++; if (rd_vld !== 4'b0000) begin n_err++; $display("FAIL rm_rd_vld_rst[%0d] got=%b want=0000", c, rd_vld); end
    end
    @(negedge clk);
    rst = 1'b0;
    req_en = '0;
    clk_step();
    n_vec++; if (rd_vld !== 4'b0000) begin n_err++; $display("FAIL rm_rd_vld_post got=%b want=0000", rd_vld); end
    @(negedge clk);
    set_req(1, 1, 'h2B);
    #1;
    n_vec++; if (req_grnt !== 3'b010) begin n_err++; $display("FAIL rm_grnt_post got=%b want=010", req_grnt); end
    clk_step();
    n_vec++; if (bank_en !== 4'b0100) begin n_err++; $display("FAIL rm_bank_en_post got=%b want=0100", bank_en); end
    n_vec++; if (bank_word[11:8] !== 4'hB) begin n_err++; $display("FAIL rm_word2 got=%h want=b", bank_word[11:8]); end
    n_vec++; if (bank_sel[5:4] !== 2'd1) begin n_err++; $display("FAIL rm_sel2 got=%0d want=1", bank_sel[5:4]); end
    @(negedge clk);
    req_en = '0;
    for (int c = 1; c <= 3; c++) begin
      clk_step();
      n_vec++;
      if (rd_vld !== ((c == 2) ? 4'b0100 : 4'b0000)) begin
        n_err++; $display("FAIL rm_rd_vld_tail[%0d] got=%b", c, rd_vld);
      end
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_en = '0;
      req_addr = NREQ*A'($urandom);
      #1;
      n_vec++; if (req_grnt !== 3'b000) begin n_err++; $display("FAIL idle_grnt got=%b want=000", req_grnt); end
      clk_step();
      n_vec++; if (bank_en !== 4'b0000) begin n_err++; $display("FAIL idle_bank_en got=%b want=0000", bank_en); end
      n_vec++; if (bank_word !== m_word) begin n_err++; $display("FAIL idle_word got=%h want=%h", bank_word, m_word); end
      n_vec++; if (bank_sel !== m_sel) begin n_err++; $display("FAIL idle_sel got=%h want=%h", bank_sel, m_sel); end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g_prev = '0;
    logic [NREQ-1:0] g_exp;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      for (int r = 0; r < NREQ; r++) begin
        // A pending, ungranted request must hold its address.
        if (!req_en[r] || g_prev[r]) begin
          set_req(r, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)));
        end
      end
      #1;
      g_exp = model_grant();
      g_prev = g_exp;
      n_vec++; if (req_grnt !== g_exp) begin n_err++; $display("FAIL rnd_grnt[%0d] got=%b want=%b", c, req_grnt, g_exp); end
      clk_step();
      n_vec++;
      if ({bank_en, bank_word, bank_sel} !== {m_en, m_word, m_sel}) begin
        n_err++;
        $display("FAIL rnd_cmd[%0d] got=%b/%h/%h want=%b/%h/%h", c, bank_en, bank_word, bank_sel,
                 m_en, m_word, m_sel);
      end
      n_vec++;
      if ({rd_vld, rd_sel} !== {m_rd_vld, m_rd_sel}) begin
        n_err++;
        $display("FAIL rnd_rd[%0d] got=%b/%h want=%b/%h", c, rd_vld, rd_sel, m_rd_vld, m_rd_sel);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    req_en = '0;
    clk_step();
  endtask

  initial begin
    for (int r = 0; r < NREQ; r++) age[r] = 0;
    test_reset();
    test_partial_conflict();
    test_back_to_back();
    test_starve();
    test_reset_midflight();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
